// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one byte-write block RAM port between two requesters.
// Define BRAM_ARB_LOCK_EN to add m0_lock/m1_lock for atomic read-modify-write sequences.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m0_req,
  output logic                          m0_gnt,
  input  logic [ADDR_WIDTH-1:0]         m0_addr,
  input  logic [NB_COL-1:0]             m0_we,
  input  logic [NB_COL*COL_WIDTH-1:0]   m0_wdata,
  output logic                          m0_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   m0_rdata,
  input  logic                          m1_req,
  output logic                          m1_gnt,
  input  logic [ADDR_WIDTH-1:0]         m1_addr,
  input  logic [NB_COL-1:0]             m1_we,
  input  logic [NB_COL*COL_WIDTH-1:0]   m1_wdata,
  output logic                          m1_rvalid,
  output logic [NB_COL*COL_WIDTH-1:0]   m1_rdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic                          m0_lock,
  input  logic                          m1_lock,
`endif
  output logic                          bram_en,
  output logic [NB_COL-1:0]             bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   bram_din,
  input  logic [NB_COL*COL_WIDTH-1:0]   bram_dout
);

  logic last_grant;
  logic pend_valid;
  logic pend_id;
  logic accept;

`ifdef BRAM_ARB_LOCK_EN
  logic lock_valid;
  logic lock_id;
`endif

  // Grants are held low during reset so every output reads 0 while rst_n is low.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
`ifdef BRAM_ARB_LOCK_EN
      if (lock_valid) begin
        m0_gnt = ~lock_id & m0_req;
        m1_gnt = lock_id & m1_req;
      end else
`endif
      begin
        if (m0_req && m1_req) begin
          m0_gnt = last_grant;
          m1_gnt = ~last_grant;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
    end
  end

  assign accept  = m0_gnt | m1_gnt;
  assign bram_en = accept;

  always_comb begin
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    if (m0_gnt) begin
      bram_we   = m0_we;
      bram_addr = m0_addr;
      bram_din  = m0_wdata;
    end else if (m1_gnt) begin
      bram_we   = m1_we;
      bram_addr = m1_addr;
      bram_din  = m1_wdata;
    end
  end

  // Remember who was served last and whether a read response is due next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_id    <= 1'b0;
    end else if (accept) begin
      last_grant <= m1_gnt;
      pend_valid <= (bram_we == '0);
      pend_id    <= m1_gnt;
    end else begin
      pend_valid <= 1'b0;
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  // Only the owner can be accepted while locked, so each accept simply reloads the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
    end else if (accept) begin
      lock_valid <= m1_gnt ? m1_lock : m0_lock;
      lock_id    <= m1_gnt;
    end
  end
`endif

  assign m0_rvalid = pend_valid & ~pend_id;
  assign m1_rvalid = pend_valid & pend_id;
  assign m0_rdata  = m0_rvalid ? bram_dout : '0;
  assign m1_rdata  = m1_rvalid ? bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, transaction-level reference model and per-scenario tasks.
// Lock scenarios are included when BRAM_ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;
  localparam int AW    = 13;
  localparam int NC    = 4;
  localparam int CW    = 8;
  localparam int DW    = NC * CW;
  localparam int DRV_W = 3 + NC + AW + DW;
  localparam int RSP_W = 2 + 2 * DW;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [NC-1:0] we [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
`ifdef BRAM_ARB_LOCK_EN
  logic [1:0] lock;
`endif
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic bram_en;
  logic [NC-1:0] bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int n_vec = 0;
  int n_err = 0;

  int last_id, lock_owner, winner, pend_id;
  bit pend_v;
  logic [DW-1:0] pend_data;
  logic [DRV_W-1:0] exp_drv, obs_drv;
  logic [RSP_W-1:0] exp_rsp, obs_rsp;

  assign obs_drv = {m0_gnt, m1_gnt, bram_en, bram_we, bram_addr, bram_din};
  assign obs_rsp = {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata};

  bram_port_arbiter #(.ADDR_WIDTH(AW), .NB_COL(NC), .COL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_gnt(m0_gnt), .m0_addr(addr[0]), .m0_we(we[0]), .m0_wdata(wdata[0]),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_gnt(m1_gnt), .m1_addr(addr[1]), .m1_we(we[1]), .m1_wdata(wdata[1]),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef BRAM_ARB_LOCK_EN
    .m0_lock(lock[0]), .m1_lock(lock[1]),
`endif
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: byte-write, one-cycle registered read.
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < NC; b++)
        if (bram_we[b]) ram[bram_addr][b*CW +: CW] <= bram_din[b*CW +: CW];
      bram_dout <= ram[bram_addr];
    end
  end

  task automatic model_reset();
    last_id    = 1;
    lock_owner = -1;
    pend_v     = 1'b0;
    pend_id    = 0;
    pend_data  = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  // Predict this cycle's grant, RAM drive and response from the transaction-level state.
  task automatic predict();
    int w;
    logic [DW-1:0] rd0, rd1;
    w = -1;
    if (rst_n) begin
`ifdef BRAM_ARB_LOCK_EN
      if (lock_owner >= 0) w = req[lock_owner] ? lock_owner : -1;
      else
`endif
      if (req == 2'b11) w = 1 - last_id;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
    end
    winner = w;
    if (w < 0) exp_drv = '0;
    else exp_drv = {w == 0, w == 1, 1'b1, we[w], addr[w], wdata[w]};
    rd0 = (pend_v && pend_id == 0) ? pend_data : '0;
    rd1 = (pend_v && pend_id == 1) ? pend_data : '0;
    exp_rsp = {pend_v && pend_id == 0, pend_v && pend_id == 1, rd0, rd1};
  endtask

  task automatic commit();
    if (!rst_n) begin
      model_reset();
      return;
    end
    pend_v = 1'b0;
    if (winner >= 0) begin
      last_id = winner;
      if (we[winner] == '0) begin
        pend_v    = 1'b1;
        pend_id   = winner;
        pend_data = shadow[addr[winner]];
      end else begin
        for (int b = 0; b < NC; b++)
          if (we[winner][b]) shadow[addr[winner]][b*CW +: CW] = wdata[winner][b*CW +: CW];
      end
`ifdef BRAM_ARB_LOCK_EN
      if (lock_owner < 0 && lock[winner]) lock_owner = winner;
      else if (lock_owner == winner && !lock[winner]) lock_owner = -1;
`endif
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic idle_inputs();
    req = 2'b00;
`ifdef BRAM_ARB_LOCK_EN
    lock = 2'b00;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req = 2'b11;
    addr[0] = 13'h0AB;
    addr[1] = 13'h1CD;
    #2;
    n_vec++;
    if (obs_drv !== '0) begin n_err++; $display("[TB] FAIL reset_drive: got %h want 0", obs_drv); end
    n_vec++;
    if (obs_rsp !== '0) begin n_err++; $display("[TB] FAIL reset_rsp: got %h want 0", obs_rsp); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req = 2'b01; we[0] = '0; addr[0] = 13'h005;
    settle();
    n_vec++;
    if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL single_read_drive: got %h want %h", obs_drv, exp_drv); end
    n_vec++;
    if ({m0_gnt, bram_en, bram_addr} !== {2'b11, 13'h005}) begin
      n_err++; $display("[TB] FAIL single_read_issue: got gnt=%b en=%b addr=%h want 1 1 005", m0_gnt, bram_en, bram_addr);
    end
    commit();
    @(negedge clk);
    idle_inputs();
    settle();
    n_vec++;
    if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL single_read_rsp: got %h want %h", obs_rsp, exp_rsp); end
    n_vec++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_err++; $display("[TB] FAIL single_read_data: got rv=%b%b data=%h want 10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
    end
    commit();
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        req = 2'b11;
        for (int m = 0; m < 2; m++) begin
          we[m] = '0;
          addr[m] = AW'($urandom_range(0, 15));
        end
      end else idle_inputs();
      settle();
      n_vec++;
      if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL contention_drive[%0d]: got %h want %h", i, obs_drv, exp_drv); end
      n_vec++;
      if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL contention_rsp[%0d]: got %h want %h", i, obs_rsp, exp_rsp); end
      if (i < 4) begin
        n_vec++;
        if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("[TB] FAIL contention_order[%0d]: got %b%b want %b", i, m0_gnt, m1_gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      commit();
    end
  endtask

  task automatic test_byte_write();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        req = 2'b10; we[1] = 4'b0011; addr[1] = 13'h010; wdata[1] = 32'h11223344;
      end else if (i == 1) begin
        req = 2'b01; we[0] = '0; addr[0] = 13'h010;
      end
      settle();
      n_vec++;
      if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL byte_write_drive[%0d]: got %h want %h", i, obs_drv, exp_drv); end
      n_vec++;
      if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL byte_write_rsp[%0d]: got %h want %h", i, obs_rsp, exp_rsp); end
      if (i == 2) begin
        n_vec++;
        if (m0_rdata !== 32'hAAAA3344) begin n_err++; $display("[TB] FAIL byte_write_merge: got %h want aaaa3344", m0_rdata); end
      end
      commit();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle_inputs();
    req = 2'b10; we[1] = '0; addr[1] = 13'h030;
    settle();
    commit();
    @(negedge clk);
    idle_inputs();
    settle();
    n_vec++;
    if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL async_pre_rsp: got %h want %h", obs_rsp, exp_rsp); end
    rst_n = 1'b0;
    req = 2'b11; we[0] = '0; we[1] = '0;
    model_reset();
    settle();
    n_vec++;
    if (obs_drv !== '0) begin n_err++; $display("[TB] FAIL async_in_reset_drive: got %h want 0", obs_drv); end
    n_vec++;
    if (obs_rsp !== '0) begin n_err++; $display("[TB] FAIL async_in_reset_rsp: got %h want 0", obs_rsp); end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    n_vec++;
    if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b100) begin
      n_err++; $display("[TB] FAIL async_first_tie: got gnt=%b%b m1_rvalid=%b want 10 0", m0_gnt, m1_gnt, m1_rvalid);
    end
    n_vec++;
    if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL async_post_drive: got %h want %h", obs_drv, exp_drv); end
    commit();
    @(negedge clk);
    idle_inputs();
    settle();
    n_vec++;
    if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL async_post_rsp: got %h want %h", obs_rsp, exp_rsp); end
    commit();
  endtask

`ifdef BRAM_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] want_gnt [5];
    want_gnt = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      we[0] = '0; addr[0] = 13'h021;
      case (i)
        0: begin req = 2'b10; we[1] = '0; addr[1] = 13'h020; lock[1] = 1'b1; end
        1: req = 2'b01;
        2: begin req = 2'b11; we[1] = 4'hF; addr[1] = 13'h020; wdata[1] = 32'h0BADF00D; lock[1] = 1'b0; end
        3: req = 2'b01;
        default: ;
      endcase
      settle();
      n_vec++;
      if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL lock_drive[%0d]: got %h want %h", i, obs_drv, exp_drv); end
      n_vec++;
      if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL lock_rsp[%0d]: got %h want %h", i, obs_rsp, exp_rsp); end
      n_vec++;
      if ({m1_gnt, m0_gnt} !== want_gnt[i]) begin
        n_err++; $display("[TB] FAIL lock_gnt[%0d]: got m1m0=%b%b want %b", i, m1_gnt, m0_gnt, want_gnt[i]);
      end
      commit();
    end
  endtask
`endif

  task automatic test_idle();
    @(negedge clk);
    idle_inputs();
    settle();
    n_vec++;
    if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL idle_drain_rsp: got %h want %h", obs_rsp, exp_rsp); end
    commit();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      settle();
      n_vec++;
      if ({obs_drv, obs_rsp} !== '0) begin
        n_err++; $display("[TB] FAIL idle[%0d]: got drive=%h rsp=%h want 0", i, obs_drv, obs_rsp);
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit hold [2];
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!hold[m] && $urandom_range(0, 99) < 60) begin
          hold[m]  = 1'b1;
          addr[m]  = AW'($urandom_range(0, 15));
          wdata[m] = $urandom;
          if ($urandom_range(0, 1) == 0) we[m] = '0;
          else we[m] = NC'($urandom_range(1, (1 << NC) - 1));
`ifdef BRAM_ARB_LOCK_EN
          lock[m] = ($urandom_range(0, 9) < 2);
`endif
        end
      end
      req = {hold[1], hold[0]};
      settle();
      n_vec++;
      if (obs_drv !== exp_drv) begin n_err++; $display("[TB] FAIL random_drive[%0d]: got %h want %h", i, obs_drv, exp_drv); end
      n_vec++;
      if (obs_rsp !== exp_rsp) begin n_err++; $display("[TB] FAIL random_rsp[%0d]: got %h want %h", i, obs_rsp, exp_rsp); end
      if (winner >= 0) hold[winner] = 1'b0;
      commit();
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      we[m] = '0;
      addr[m] = '0;
      wdata[m] = '0;
    end
    idle_inputs();
    for (int a = 0; a < (1 << AW); a++) preload(AW'(a), $urandom);
    preload(13'h005, 32'hDEADBEEF);
    preload(13'h010, 32'hAAAAAAAA);
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_async_reset();
`ifdef BRAM_ARB_LOCK_EN
    test_lock();
`endif
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the project's dual-port byte-write block RAM between two requesters, e.g. instruction fetch (m0) and load/store unit (m1).
- Performs round-robin arbitration with a valid/grant handshake, drives the RAM port and routes the 1-cycle read data back to the requester that issued the read.
- Sits between the core's memory interfaces and one RAM port configured for 1-cycle read latency with no output register.

Parameters:
ADDR_WIDTH, 13, word address width (8192 words)
NB_COL, 4, byte lanes per word
COL_WIDTH, 8, bits per byte lane

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 access valid
m0_gnt  out  1  requester 0 accepted this cycle
m0_addr  in  ADDR_WIDTH  requester 0 word address
m0_we  in  NB_COL  requester 0 byte write enables; all zero means read
m0_wdata  in  NB_COL*COL_WIDTH  requester 0 write data
m0_rvalid  out  1  requester 0 read data valid
m0_rdata  out  NB_COL*COL_WIDTH  requester 0 read data
m1_*  same seven signals for requester 1
bram_en  out  1  RAM port enable
bram_we  out  NB_COL  RAM byte write enables
bram_addr  out  ADDR_WIDTH  RAM address
bram_din  out  NB_COL*COL_WIDTH  RAM write data
bram_dout  in  NB_COL*COL_WIDTH  RAM read data, valid 1 cycle after bram_en
m0_lock, m1_lock  in  1  only present with the optional feature

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - last_grant := 1, so m0 wins the first tie.
  - pend_valid := 0, pend_id := 0, lock_owner cleared.
  - All outputs are 0: gnt, rvalid, rdata, bram_en, bram_we, bram_addr, bram_din.
- **Grant** (combinational from req and registered state):
  - Only m0 requesting: m0 is granted.
  - Only m1 requesting: m1 is granted.
  - Both requesting: the requester other than last_grant is granted.
  - At most one gnt is high per cycle. A transfer is accepted when req and gnt are both high.
- **RAM drive:**
  - bram_en = m0_gnt | m1_gnt.
  - bram_addr, bram_we and bram_din are muxed from the granted requester.
  - With no grant, all four RAM outputs are 0.
- **Registered updates** on each accepted transfer:
  - last_grant := granted id.
  - pend_valid := (granted we == 0), pend_id := granted id.
  - With no accept, pend_valid := 0.
- **Read response:**
  - mX_rvalid = pend_valid & (pend_id == X).
  - mX_rdata = bram_dout when mX_rvalid, else 0.
  - Read latency is exactly 1 cycle after accept, with no back-pressure. Requesters must sample rdata in the rvalid cycle.
- **Writes:** no rvalid; a write completes at accept.
  - Partial byte enables write only the selected lanes.
  - A read issued the cycle after a write to the same address returns the new data.
- **Throughput:**
  - One access per cycle; back-to-back reads from either requester are allowed.
  - Alternating grants under continuous contention give each requester 50% of the bandwidth.
  - Worst-case wait for a requester holding req high is 1 cycle.
- **Request stability:** while req is high and gnt is low, the requester holds addr, we and wdata stable. The arbiter does not check this.
- **Reset mid-operation:** a pending read response is discarded; rvalid is not asserted after reset release until a new read is accepted.

Optional Feature:
Macro BRAM_ARB_LOCK_EN.
- **Defined:**
  - mX_lock ports exist.
  - An accept with mX_lock high sets lock_owner := X.
  - While lock_owner is set, only the owner can be granted, even if the other requester is waiting, and even on cycles where the owner has no req.
  - lock_owner clears on the first owner accept with mX_lock low, or on reset.
  - Used for atomic read-modify-write sequences.
- **Undefined:** no lock ports; pure round-robin as above.

Test Plan:
1. **Single read:** after reset, m0 reads addr 0x005 (RAM holds 0xDEADBEEF) → m0_gnt=1 same cycle, bram_en=1, bram_addr=0x005; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
2. **Contention:** m0 and m1 both hold req for 4 cycles → grants go m0, m1, m0, m1; each read's rvalid/rdata is routed only to its issuer, 1 cycle later.
3. **Byte write:** m1 writes addr 0x010 with we=4'b0011, wdata=0x11223344 over prior 0xAAAAAAAA → no rvalid; the next m0 read of 0x010 returns 0xAAAA3344.
4. **Async reset:** rst_n pulsed low in the cycle after an accepted m1 read → m1_rvalid=0 immediately and stays 0 after release; all outputs are 0 during reset; the first post-reset tie is granted to m0.
5. **Lock** (BRAM_ARB_LOCK_EN): m1 reads 0x020 with m1_lock=1 while m0 requests continuously; m1 writes 0x020 with m1_lock=0 two cycles later → m0_gnt=0 until the m1 write is accepted, then m0_gnt=1 on the next cycle.
6. **Idle:** no requests for 10 cycles → bram_en=0 throughout, all rvalid=0, rdata=0.
